// File: rtl/regfile_pkg.sv
// Shared types, default sizes and the clear-engine initial value rule
// for the parametrised RV32I register file.
package regfile_pkg;

    // Clear engine states: CLEAR walks the array, IDLE serves the core.
    typedef enum logic {
        RF_CLEAR = 1'b0,
        RF_IDLE  = 1'b1
    } rf_state_t;

    // Default geometry of the register file.
    localparam int RF_XLEN  = 32;
    localparam int RF_NREGS = 32;

    // Widest data path the init function can describe; callers size-cast down.
    localparam int RF_MAX_XLEN = 64;

    // Value loaded into register idx by the clear engine: the stack pointer
    // register gets its boot value, every other register starts at zero.
    function automatic logic [RF_MAX_XLEN-1:0] rf_init_val(
        input int unsigned            idx,
        input int unsigned            sp_idx,
        input logic [RF_MAX_XLEN-1:0] sp_init
    );
        return (idx == sp_idx) ? sp_init : '0;
    endfunction

endpackage

// File: rtl/rf_clear_seq.sv
// Clear engine: after reset or on request, writes the initial value of one
// register per cycle, then reports the file as ready.
module rf_clear_seq
    import regfile_pkg::*;
#(
    parameter int               XLEN    = RF_XLEN,
    parameter int               NREGS   = RF_NREGS,
    parameter int               SP_IDX  = 2,
    parameter logic [XLEN-1:0]  SP_INIT = XLEN'(100),
    localparam int              AW      = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr_req,
    output logic            clr_we,
    output logic [AW-1:0]   clr_addr,
    output logic [XLEN-1:0] clr_data,
    output logic            ready
);

    localparam logic [AW-1:0]          LAST_IDX    = AW'(NREGS - 1);
    localparam logic [RF_MAX_XLEN-1:0] SP_INIT_EXT = RF_MAX_XLEN'(SP_INIT);

    rf_state_t       state_reg, state_next;
    logic [AW-1:0]   cnt_reg,   cnt_next;

    // State and index registers; reset always lands in a fresh clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= RF_CLEAR;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Next state: CLEAR steps through every index once; IDLE only leaves on
    // a clear request. Requests during CLEAR are ignored so a clear is never
    // restarted half way.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            RF_CLEAR: begin
                if (cnt_reg == LAST_IDX) begin
                    state_next = RF_IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next   = cnt_reg + AW'(1);
                end
            end
            RF_IDLE: begin
                if (clr_req) begin
                    state_next = RF_CLEAR;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = RF_CLEAR;
                cnt_next   = '0;
            end
        endcase
    end

    // Write port towards the array: active for every cycle spent in CLEAR.
    always_comb begin
        clr_we   = (state_reg == RF_CLEAR);
        clr_addr = cnt_reg;
        clr_data = XLEN'(rf_init_val(32'(cnt_reg), SP_IDX, SP_INIT_EXT));
        ready    = (state_reg == RF_IDLE);
    end

endmodule

// File: rtl/banco_registros_param.sv
// Parametrised general-purpose register file: NRD combinational read ports,
// one write port with optional write-to-read bypass, hardwired-zero x0 and a
// sequential clear engine so the storage needs no reset of its own.
module banco_registros_param
    import regfile_pkg::*;
#(
    parameter int               XLEN    = RF_XLEN,
    parameter int               NREGS   = RF_NREGS,
    parameter int               NRD     = 2,
    parameter int               SP_IDX  = 2,
    parameter logic [XLEN-1:0]  SP_INIT = XLEN'(100),
    parameter bit               BYPASS  = 1'b1,
    localparam int              AW      = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                we,
    input  logic [AW-1:0]       waddr,
    input  logic [XLEN-1:0]     wdata,
    input  logic [NRD*AW-1:0]   raddr,
    output logic [NRD*XLEN-1:0] rdata,
    input  logic                clr_req,
    output logic                ready
);

    logic [XLEN-1:0] mem [NREGS];

    logic            clr_we;
    logic [AW-1:0]   clr_addr;
    logic [XLEN-1:0] clr_data;

    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [XLEN-1:0] wr_data;

    rf_clear_seq #(
        .XLEN    (XLEN),
        .NREGS   (NREGS),
        .SP_IDX  (SP_IDX),
        .SP_INIT (SP_INIT)
    ) u_clear_seq (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_req  (clr_req),
        .clr_we   (clr_we),
        .clr_addr (clr_addr),
        .clr_data (clr_data),
        .ready    (ready)
    );

    // Write mux: the clear engine owns the port while clearing; otherwise the
    // writeback port writes any register except x0.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = waddr;
        wr_data = wdata;
        if (clr_we) begin
            wr_en   = 1'b1;
            wr_addr = clr_addr;
            wr_data = clr_data;
        end else if (we && (waddr != '0)) begin
            wr_en   = 1'b1;
        end
    end

    // Storage array; no reset so it can map onto distributed RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    generate
        for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
            logic [AW-1:0]   port_addr;
            logic [XLEN-1:0] port_data;

            assign port_addr = raddr[gi*AW +: AW];

            // Read port: zero until initialised and for x0; an in-flight
            // write to the same register is forwarded when bypass is enabled.
            always_comb begin
                port_data = '0;
                if (!ready || (port_addr == '0)) begin
                    port_data = '0;
                end else if (BYPASS && we && (waddr == port_addr)) begin
                    port_data = wdata;
                end else begin
                    port_data = mem[port_addr];
                end
            end

            assign rdata[gi*XLEN +: XLEN] = port_data;
        end
    endgenerate

endmodule

// File: tb/tb_banco_registros_param.sv
// Bench for banco_registros_param: two instances (3 ports with bypass,
// 2 ports without) share the write/clear stimulus and are compared against
// an array-based behavioural model of the register file.
module tb_banco_registros_param;

    localparam int AW = 5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        we = 1'b0;
    logic [4:0]  waddr = '0;
    logic [31:0] wdata = '0;
    logic        clr_req = 1'b0;
    logic [14:0] raddr_a = '0;
    logic [9:0]  raddr_b;
    logic [95:0] rdata_a;
    logic [63:0] rdata_b;
    logic        ready_a, ready_b;

    int errors = 0;
    int checks = 0;

    assign raddr_b = raddr_a[9:0];

    always #5 clk = ~clk;

    banco_registros_param #(.NRD(3), .BYPASS(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr(raddr_a), .rdata(rdata_a), .clr_req(clr_req), .ready(ready_a)
    );

    banco_registros_param #(.NRD(2), .BYPASS(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr(raddr_b), .rdata(rdata_b), .clr_req(clr_req), .ready(ready_b)
    );

    // Behavioural model: contents plus number of clear writes still pending.
    logic [31:0] mm [32];
    int clear_left = 32;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clear_left = 32;
        end else if (clear_left > 0) begin
            mm[32 - clear_left] = (32 - clear_left == 2) ? 32'd100 : 32'd0;
            clear_left = clear_left - 1;
        end else begin
            if (we && waddr != 0) mm[waddr] = wdata;
            if (clr_req) clear_left = 32;
        end
    end

    function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
        if (clear_left != 0) return 32'd0;
        if (a == 0) return 32'd0;
        if (byp && we && waddr == a) return wdata;
        return mm[a];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int n;
        rst_n = 1'b0;
        raddr_a = {5'd2, 5'd7, 5'd2};
        step();
        step();
        checks++;
        if (ready_a !== 1'b0 || ready_b !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: got a=%b b=%b expected 0", ready_a, ready_b);
        end
        checks++;
        if (rdata_a !== 96'd0 || rdata_b !== 64'd0) begin
            errors++;
            $display("FAIL reset_rdata: got a=%h b=%h expected 0", rdata_a, rdata_b);
        end
        rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (ready_a) break;
            n++;
            step();
        end
        checks++;
        if (n !== 32 || ready_b !== 1'b1) begin
            errors++;
            $display("FAIL reset_clear_len: got %0d cycles low (ready_b=%b) expected 32", n, ready_b);
        end
        for (int a = 0; a < 32; a++) begin
            raddr_a = {a[4:0], a[4:0], a[4:0]};
            #1;
            checks++;
            if (rdata_a[31:0] !== ((a == 2) ? 32'd100 : 32'd0) ||
                rdata_a[95:64] !== ((a == 2) ? 32'd100 : 32'd0) ||
                rdata_b[63:32] !== ((a == 2) ? 32'd100 : 32'd0)) begin
                errors++;
                $display("FAIL reset_init_reg%0d: got a0=%h a2=%h b1=%h", a, rdata_a[31:0], rdata_a[95:64], rdata_b[63:32]);
            end
        end
        $display("reset: cleared in %0d cycles, init values swept", n);
    endtask

    task automatic test_bypass();
        we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
        raddr_a = {5'd0, 5'd0, 5'd5};
        #1;
        checks++;
        if (rdata_a[31:0] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL bypass_same_cycle: got %h expected deadbeef", rdata_a[31:0]);
        end
        checks++;
        if (rdata_b[31:0] !== 32'h0) begin
            errors++;
            $display("FAIL nobypass_same_cycle: got %h expected 00000000", rdata_b[31:0]);
        end
        step();
        we = 1'b0;
        #1;
        checks++;
        if (rdata_a[31:0] !== 32'hDEADBEEF || rdata_b[31:0] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL write_next_cycle: got a=%h b=%h expected deadbeef", rdata_a[31:0], rdata_b[31:0]);
        end
        $display("bypass: reg5 a=%h b=%h", rdata_a[31:0], rdata_b[31:0]);
    endtask

    task automatic test_zero_write();
        we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF;
        raddr_a = '0;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (rdata_a !== 96'd0 || rdata_b !== 64'd0) begin
                errors++;
                $display("FAIL zero_reg cycle %0d: got a=%h b=%h expected 0", c, rdata_a, rdata_b);
            end
            step();
            we = 1'b0;
        end
        $display("zero_write: x0 reads %h", rdata_a[31:0]);
    endtask

    task automatic test_multi_port();
        we = 1'b1; waddr = 5'd7; wdata = 32'h12345678;
        step();
        we = 1'b0;
        raddr_a = {5'd7, 5'd7, 5'd7};
        #1;
        for (int p = 0; p < 3; p++) begin
            checks++;
            if (rdata_a[p*32 +: 32] !== 32'h12345678) begin
                errors++;
                $display("FAIL multi_port%0d: got %h expected 12345678", p, rdata_a[p*32 +: 32]);
            end
        end
        $display("multi_port: %h %h %h", rdata_a[31:0], rdata_a[63:32], rdata_a[95:64]);
    endtask

    task automatic test_random();
        int bad = 0;
        for (int c = 0; c < 200; c++) begin
            we = 1'($urandom_range(0, 1));
            waddr = 5'($urandom);
            wdata = $urandom;
            raddr_a = 15'($urandom);
            if (c % 4 == 0) raddr_a[4:0] = waddr;
            #1;
            for (int p = 0; p < 3; p++) begin
                checks++;
                if (rdata_a[p*32 +: 32] !== exp_rd(raddr_a[p*5 +: 5], 1'b1)) begin
                    errors++; bad++;
                    $display("FAIL rand_a cyc %0d port%0d: got %h expected %h", c, p, rdata_a[p*32 +: 32], exp_rd(raddr_a[p*5 +: 5], 1'b1));
                end
            end
            for (int p = 0; p < 2; p++) begin
                checks++;
                if (rdata_b[p*32 +: 32] !== exp_rd(raddr_b[p*5 +: 5], 1'b0)) begin
                    errors++; bad++;
                    $display("FAIL rand_b cyc %0d port%0d: got %h expected %h", c, p, rdata_b[p*32 +: 32], exp_rd(raddr_b[p*5 +: 5], 1'b0));
                end
            end
            step();
        end
        we = 1'b0;
        $display("random: 200 cycles, %0d bad reads", bad);
    endtask

    task automatic test_clear();
        int n;
        we = 1'b1; waddr = 5'd9; wdata = 32'h55;
        step();
        clr_req = 1'b1; we = 1'b1; waddr = 5'd9; wdata = 32'hAA;
        raddr_a = {5'd0, 5'd0, 5'd9};
        #1;
        checks++;
        if (rdata_a[31:0] !== 32'hAA || rdata_b[31:0] !== 32'h55) begin
            errors++;
            $display("FAIL clear_req_cycle: got a=%h b=%h expected aa/55", rdata_a[31:0], rdata_b[31:0]);
        end
        step();
        clr_req = 1'b0;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (ready_a) break;
            n++;
            checks++;
            if (rdata_a[31:0] !== 32'h0 || ready_b !== 1'b0) begin
                errors++;
                $display("FAIL clear_reads cycle %0d: got %h ready_b=%b expected 0", i, rdata_a[31:0], ready_b);
            end
            we = 1'($urandom_range(0, 1));
            waddr = (i % 2 == 0) ? 5'd9 : 5'd2;
            wdata = $urandom;
            clr_req = (i == 5 || i == 30);
            raddr_a = 15'($urandom);
            step();
        end
        we = 1'b0; clr_req = 1'b0;
        checks++;
        if (n !== 32) begin
            errors++;
            $display("FAIL clear_len: got %0d cycles low expected 32", n);
        end
        raddr_a = {5'd0, 5'd2, 5'd9};
        #1;
        checks++;
        if (rdata_a[31:0] !== 32'h0 || rdata_a[63:32] !== 32'd100 || rdata_b[63:32] !== 32'd100) begin
            errors++;
            $display("FAIL clear_values: got r9=%h r2=%h expected 0/100", rdata_a[31:0], rdata_a[63:32]);
        end
        $display("clear: ready low %0d cycles, r9=%h r2=%0d", n, rdata_a[31:0], rdata_a[63:32]);
    endtask

    task automatic test_reset_mid_clear();
        int n;
        we = 1'b1; waddr = 5'd20; wdata = 32'h77;
        step();
        we = 1'b0; clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        for (int i = 0; i < 10; i++) step();
        rst_n = 1'b0;
        #1;
        checks++;
        if (ready_a !== 1'b0 || rdata_a !== 96'd0) begin
            errors++;
            $display("FAIL midclear_reset: got ready=%b rdata=%h expected 0", ready_a, rdata_a);
        end
        step();
        rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (ready_a) break;
            n++;
            step();
        end
        checks++;
        if (n !== 32 || ready_b !== 1'b1) begin
            errors++;
            $display("FAIL midclear_len: got %0d cycles low expected 32", n);
        end
        raddr_a = {5'd9, 5'd2, 5'd20};
        #1;
        checks++;
        if (rdata_a[31:0] !== 32'h0 || rdata_a[63:32] !== 32'd100 || rdata_a[95:64] !== 32'h0) begin
            errors++;
            $display("FAIL midclear_values: got r20=%h r2=%h r9=%h expected 0/100/0", rdata_a[31:0], rdata_a[63:32], rdata_a[95:64]);
        end
        $display("reset_mid_clear: ready low %0d cycles, r20=%h", n, rdata_a[31:0]);
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_zero_write();
        test_multi_port();
        test_random();
        test_clear();
        test_reset_mid_clear();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/banco_registros_param.md
# banco_registros_param

Parametrised general-purpose register file for the RV32I core, replacing the fixed 32×32, two-read-port bank. It provides a configurable number of combinational read ports, one write port with optional same-cycle write-to-read bypass, and a hardwired-zero register 0. A sequential clear engine initialises the storage one register per cycle after reset or on request, so the array can map to distributed RAM. Sits between decode (read addresses), writeback (write port) and the hazard unit (`ready`).

## Interface
- `XLEN`, 32, data width in bits
- `NREGS`, 32, number of registers (power of two, ≥4); `AW = $clog2(NREGS)`
- `NRD`, 2, number of read ports (1–4)
- `SP_IDX`, 2, index of the register initialised to `SP_INIT`
- `SP_INIT`, 100, initial value of register `SP_IDX`
- `BYPASS`, 1, 1 = a read of the register being written returns `wdata` in the same cycle

- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `we`  in  1  write enable
- `waddr`  in  AW  write register index
- `wdata`  in  XLEN  write data
- `raddr`  in  NRD*AW  read indices; port i occupies `[i*AW +: AW]`
- `rdata`  out  NRD*XLEN  read data; port i occupies `[i*XLEN +: XLEN]`
- `clr_req`  in  1  single-cycle request to reinitialise all registers
- `ready`  out  1  1 = file initialised; writes accepted and reads valid

## Operation
- States: CLEAR and IDLE. The index counter `cnt` is AW bits wide.
- While `rst_n` is 0: state = CLEAR, `cnt` = 0, `ready` = 0. Array contents are not reset directly.
- CLEAR, each rising edge:
  - write init(`cnt`) to register `cnt`; init(`SP_IDX`) = `SP_INIT`, all other indices 0;
  - if `cnt` == NREGS-1, go to IDLE and set `ready` = 1; otherwise increment `cnt`.
- IDLE:
  - If `we` = 1 and `waddr` ≠ 0, the register is written at the edge.
  - If `clr_req` = 1: go to CLEAR, set `cnt` = 0 and `ready` = 0. A write in the same cycle is still performed.
- In CLEAR, `we` is ignored and `clr_req` is ignored; a clear in progress is never restarted.
- Writes to register 0 are dropped in every state.
- Read port i (combinational):
  - `ready` = 0 → 0;
  - `raddr_i` = 0 → 0;
  - `BYPASS` = 1 and `we` = 1 and `waddr` = `raddr_i` → `wdata`;
  - otherwise → the stored value.
- All read ports are independent; any number of ports may address the same register.

## Timing
- Reset values: `ready` = 0, every `rdata` port = 0.
- After `rst_n` deasserts, `ready` rises after the NREGS-th rising edge (32 edges by default).
- `clr_req` sampled at edge k:
  - `ready` falls after edge k;
  - registers 0..NREGS-1 are written at edges k+1..k+NREGS;
  - `ready` rises after edge k+NREGS.
- Write latency:
  - stored value is visible one cycle after the write edge;
  - with `BYPASS` = 1 it is visible combinationally in the write cycle itself.
- Reset asserted mid-CLEAR or mid-IDLE: immediate return to CLEAR with `cnt` = 0, and a full clear runs after release.
- `cnt` wraps only through the IDLE transition; it never exceeds NREGS-1.

## Structure
- Package `regfile_pkg` holds:
  - the state enum `rf_state_t` {RF_CLEAR, RF_IDLE};
  - the default `XLEN`/`NREGS` constants;
  - the function `rf_init_val(idx, sp_idx, sp_init)`.
- Sub-module `rf_clear_seq` contains the FSM and counter. Its outputs are `clr_we`, `clr_addr`, `clr_data` and `ready`.
- The top level holds:
  - the storage array;
  - a write mux selecting clear-engine vs. external write;
  - a `generate` loop over the NRD read ports.

## Test plan
- Reset release with defaults → `ready` = 0 for 32 edges, then 1. All ports read 0 except `raddr` = 2, which reads 100.
- Write reg 5 ← 0xDEADBEEF, read it on port 0 in the same cycle:
  - `BYPASS` = 1 → 0xDEADBEEF in that cycle;
  - `BYPASS` = 0 → old value 0, then 0xDEADBEEF next cycle.
- Write reg 0 ← 0xFFFFFFFF → port reads of reg 0 return 0 in that cycle and in all later cycles.
- NRD = 3, all ports address reg 7 holding 0x12345678 → all three `rdata` slices = 0x12345678.
- `clr_req` while reg 9 = 0x55 and `we` to reg 9 ← 0xAA in the same cycle:
  - `ready` low for exactly 32 cycles;
  - `we` during CLEAR has no effect;
  - afterwards reg 9 = 0 and reg 2 = 100.
- Assert `rst_n` = 0 mid-clear at `cnt` = 10 for 1 cycle → full 32-edge clear after release, then `ready` = 1.
